// File: rtl/imem_ctrl.sv
// Clocked instruction memory for the fetch stage: registered one-cycle fetch with
// fault detection, streaming program-load port, and a NOP clear sweep after reset.
module imem_ctrl #(
    parameter int              DATA_W = 32,
    parameter int              DEPTH  = 64,
    parameter int              ADDR_W = 32,
    parameter logic [DATA_W-1:0] NOP  = '0,
    localparam int             IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [DATA_W-1:0] load_data,
    output logic [IDX_W-1:0]  load_ptr,
    output logic              load_ovf,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    output logic              ready
);

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_data;
    logic               load_entry;

    logic               accept;
    logic [ADDR_W-1:0]  idx_full;
    logic               fault;

    // Full-width index compare so high address bits can never alias into the array.
    assign idx_full = fetch_addr >> 2;
    assign fault    = (fetch_addr[1:0] != 2'b00) || (idx_full >= ADDR_W'(DEPTH));
    assign accept   = ready && fetch_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = clr_cnt;
        wr_data    = NOP;
        load_entry = 1'b0;
        case (state)
            S_CLEAR: begin
                wr_en = 1'b1;
                if (clr_cnt == IDX_W'(DEPTH - 1)) state_next = S_RUN;
            end
            S_RUN: begin
                ready = 1'b1;
                if (clear) begin
                    state_next = S_CLEAR;
                end else if (load_en) begin
                    state_next = S_LOAD;
                    load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                wr_en   = load_we;
                wr_idx  = load_ptr;
                wr_data = load_data;
                if (!load_en) state_next = S_RUN;
            end
            default: state_next = S_CLEAR;
        endcase
    end

    // Array has no reset; only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
        end else if (state == S_RUN && clear) begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ptr <= '0;
            load_ovf <= 1'b0;
        end else if (load_entry) begin
            load_ptr <= '0;
            load_ovf <= 1'b0;
        end else if (state == S_LOAD && load_we) begin
            load_ptr <= load_ptr + IDX_W'(1);
            if (load_ptr == IDX_W'(DEPTH - 1)) load_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= NOP;
        end else if (accept) begin
            fetch_valid <= 1'b1;
            fetch_fault <= fault;
            fetch_data  <= fault ? NOP : mem[fetch_addr[IDX_W+1:2]];
        end else begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: reset/sweep timing, load and fetch, faults,
// pointer wrap, clear sequencing and reset during load.
module tb_imem_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear, load_en, load_we;
    logic [DATA_W-1:0] load_data;
    logic [5:0]        load_ptr;
    logic              load_ovf;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              ready;

    int total  = 0;
    int passed = 0;

    imem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(32'h0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load_en(load_en), .load_we(load_we),
        .load_data(load_data), .load_ptr(load_ptr), .load_ovf(load_ovf),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_fault(fetch_fault), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check({tag, ".valid"}, 64'(fetch_valid), 64'd1);
        check({tag, ".data"},  64'(fetch_data),  64'(exp_data));
        check({tag, ".fault"}, 64'(fetch_fault), 64'(exp_fault));
    endtask

    // Sweep takes DEPTH edges; ready stays low through edge DEPTH-1.
    task automatic wait_sweep(input string tag);
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check({tag, ".ready_low"}, 64'(ready), 64'd0);
        tick();
        check({tag, ".ready_high"}, 64'(ready), 64'd1);
    endtask

    logic [31:0] prog [5] = '{32'h20080020, 32'h20090037, 32'hAC090000,
                              32'h8C090004, 32'h8C0B0000};

    initial begin
        reset = 1'b0; clear = 1'b0; load_en = 1'b0; load_we = 1'b0;
        load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
        #12;
        check("rst.valid", 64'(fetch_valid), 64'd0);
        check("rst.fault", 64'(fetch_fault), 64'd0);
        check("rst.data",  64'(fetch_data),  64'd0);
        check("rst.ready", 64'(ready),       64'd0);
        check("rst.ptr",   64'(load_ptr),    64'd0);
        check("rst.ovf",   64'(load_ovf),    64'd0);

        @(posedge clk); #1 reset = 1'b1;
        // ready must ignore requests during the sweep
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("sweep.noaccept", 64'(fetch_valid), 64'd0);
        for (int i = 0; i < DEPTH - 2; i++) tick();
        check("init.ready_low", 64'(ready), 64'd0);
        tick();
        check("init.ready_high", 64'(ready), 64'd1);
        fetch("f0",  32'h0,  32'h0, 1'b0);
        fetch("f4",  32'h4,  32'h0, 1'b0);
        fetch("ffc", 32'hFC, 32'h0, 1'b0);

        // five-word program
        load_en = 1'b1; tick();
        check("load.ready", 64'(ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            load_we = 1'b1; load_data = prog[i]; tick();
        end
        load_we = 1'b0; load_en = 1'b0; tick();
        check("load.ptr", 64'(load_ptr), 64'd5);
        check("load.ovf", 64'(load_ovf), 64'd0);
        check("load.ready", 64'(ready), 64'd1);
        for (int i = 0; i < 5; i++) fetch($sformatf("prog%0d", i), 32'(i * 4), prog[i], 1'b0);
        tick();
        check("idle.valid", 64'(fetch_valid), 64'd0);
        check("idle.hold",  64'(fetch_data),  64'(prog[4]));

        fetch("mis2",   32'h2,         32'h0, 1'b1);
        fetch("oor100", 32'h100,       32'h0, 1'b1);
        fetch("hi8000", 32'h8000_0000, 32'h0, 1'b1);
        fetch("ok_after_fault", 32'h8, prog[2], 1'b0);

        // 66-word load wraps the pointer
        load_en = 1'b1; tick();
        for (int i = 0; i < 66; i++) begin
            load_we = 1'b1; load_data = 32'(i); tick();
        end
        load_we = 1'b0; load_en = 1'b0; tick();
        check("wrap.ptr", 64'(load_ptr), 64'd2);
        check("wrap.ovf", 64'(load_ovf), 64'd1);
        fetch("wrap0", 32'h0,  32'd64, 1'b0);
        fetch("wrap1", 32'h4,  32'd65, 1'b0);
        fetch("wrap2", 32'h8,  32'd2,  1'b0);
        fetch("wrap63", 32'hFC, 32'd63, 1'b0);

        // clear and load_en together: clear wins
        clear = 1'b1; load_en = 1'b1; tick();
        clear = 1'b0; load_en = 1'b0;
        check("clr.ready0", 64'(ready), 64'd0);
        wait_sweep("clr");
        check("clr.ovf_sticky", 64'(load_ovf), 64'd1);
        fetch("clr0",  32'h0,  32'h0, 1'b0);
        fetch("clr8",  32'h8,  32'h0, 1'b0);
        fetch("clrfc", 32'hFC, 32'h0, 1'b0);

        // clear inside LOAD is ignored; LOAD entry resets pointer/overflow
        load_en = 1'b1; tick();
        check("ld2.ptr", 64'(load_ptr), 64'd0);
        check("ld2.ovf", 64'(load_ovf), 64'd0);
        load_we = 1'b1; load_data = 32'hCAFE_0001; clear = 1'b1; tick();
        clear = 1'b0;
        // write in the exit cycle still lands
        load_data = 32'hCAFE_0002; load_en = 1'b0; tick();
        load_we = 1'b0;
        check("ld2.ready", 64'(ready), 64'd1);
        check("ld2.ptr2", 64'(load_ptr), 64'd2);
        fetch("ld2_0", 32'h0, 32'hCAFE_0001, 1'b0);
        fetch("ld2_1", 32'h4, 32'hCAFE_0002, 1'b0);

        // reset during LOAD
        load_en = 1'b1; tick();
        load_we = 1'b1; load_data = 32'hDEAD_BEEF; tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("mid.ptr",   64'(load_ptr),    64'd0);
        check("mid.data",  64'(fetch_data),  64'd0);
        check("mid.valid", 64'(fetch_valid), 64'd0);
        check("mid.ready", 64'(ready),       64'd0);
        load_we = 1'b0; load_en = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        wait_sweep("mid");
        fetch("mid0", 32'h0, 32'h0, 1'b0);
        fetch("mid4", 32'h4, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
